keypad_scan_fifo: RTL and testbench

Parametrised matrix-keypad scanner for the Gobang keyboard IP: drives ROWS rows active-low in turn, samples COLS active-low columns, debounces whole-matrix snapshots and queues press/release events in a FIFO. Software reads it through a simple register port behind the IP's AXI4-Lite wrapper. It generalises the fixed 4x4 keyboard to any matrix up to 32 keys and adds event queueing, overflow tracking and an interrupt.

---
 rtl/keypad_scan_fifo.sv | 204 ++++++++++++++++++++
 tb/tb_keypad_scan_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: row-strobed scan, whole-snapshot debounce, press/release event FIFO, register port, irq.
// Optional feature: define KEYPAD_GHOST_REJECT_EN to drop snapshots with more than two keys pressed.
module keypad_scan_fifo #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic            ACLK,
    input  logic            ARESET,
    output logic [ROWS-1:0] row_o,
    input  logic [COLS-1:0] col_i,
    input  logic [1:0]      reg_addr,
    input  logic            reg_wr,
    input  logic [31:0]     reg_wdata,
    input  logic            reg_rd,
    output logic [31:0]     reg_rdata,
    output logic            reg_rvalid,
    output logic            irq
);
    localparam int                DIV_W    = $clog2(SCAN_DIV);
    localparam int                AW       = $clog2(FIFO_DEPTH);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [2:0]        ROW_LAST = 3'(ROWS - 1);
    localparam logic [4:0]        KEY_LAST = 5'(ROWS * COLS - 1);
    localparam logic [3:0]        DEB      = 4'(DEBOUNCE_SCANS);
    localparam logic [ROWS-1:0]   ROW0     = ROWS'(1);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

    state_t           state;
    logic [COLS-1:0]  col_s1, col_s2;
    logic [2:0]       row_idx;
    logic [DIV_W-1:0] div_cnt;
    logic [31:0]      snapshot, snap_next, prev_snap, keymap;
    logic [3:0]       stable_cnt, cnt_next;
    logic [4:0]       emit_idx;
    logic             ctrl_en, ctrl_irq_en, overflow, ghost;
    logic [8:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [6:0]       count;
    logic             empty, full, flush, ovf_clr, pop, push_req, push;
    logic [31:0]      status;
    logic             unused_wdata;

    assign unused_wdata = ^{reg_wdata[31:11], reg_wdata[9:3]};

    assign empty    = (count == 7'd0);
    assign full     = (count == 7'(FIFO_DEPTH));
    assign flush    = reg_wr && reg_addr == 2'd0 && reg_wdata[2];
    assign ovf_clr  = reg_wr && reg_addr == 2'd1 && reg_wdata[10];
    assign pop      = reg_rd && reg_addr == 2'd2 && !empty;
    assign push_req = (state == EMIT) && (prev_snap[emit_idx] != keymap[emit_idx]);
    assign push     = push_req && (!full || pop) && !flush;
    assign status   = {20'd0, ghost, overflow, full, empty, 1'b0, count};

    // Current row's columns merged into the partially built snapshot.
    always_comb begin
        snap_next = snapshot;
        for (int c = 0; c < COLS; c++)
            snap_next[5'(int'(row_idx) * COLS + c)] = ~col_s2[c];
        cnt_next = (snap_next == prev_snap) ? ((stable_cnt == 4'hF) ? 4'hF : stable_cnt + 4'd1) : 4'd1;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            col_s1 <= '1;
            col_s2 <= '1;
        end else begin
            col_s1 <= col_i;
            col_s2 <= col_s1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= IDLE;
            row_o      <= '1;
            row_idx    <= '0;
            div_cnt    <= '0;
            snapshot   <= '0;
            prev_snap  <= '0;
            stable_cnt <= '0;
            keymap     <= '0;
            emit_idx   <= '0;
            ghost      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ctrl_en) begin
                    state   <= SCAN;
                    row_idx <= '0;
                    div_cnt <= '0;
                    row_o   <= ~ROW0;
                end
                SCAN: if (!ctrl_en) begin
                    state <= IDLE;
                    row_o <= '1;
                end else if (div_cnt != DIV_LAST) begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end else begin
                    div_cnt  <= '0;
                    snapshot <= snap_next;
                    if (row_idx != ROW_LAST) begin
                        row_idx <= row_idx + 3'd1;
                        row_o   <= ~(ROW0 << (row_idx + 3'd1));
                    end else begin
                        row_idx   <= '0;
                        prev_snap <= snap_next;
`ifdef KEYPAD_GHOST_REJECT_EN
                        if ($countones(snap_next) > 2) begin
                            stable_cnt <= '0;
                            ghost      <= 1'b1;
                            row_o      <= ~ROW0;
                        end else
`endif
                        begin
                            stable_cnt <= cnt_next;
                            if (cnt_next >= DEB && snap_next != keymap) begin
                                state    <= EMIT;
                                row_o    <= '1;
                                emit_idx <= '0;
                            end else begin
                                row_o <= ~ROW0;
                            end
                        end
                    end
                end
                // The walk always completes so KEYMAP matches the events queued.
                EMIT: if (emit_idx != KEY_LAST) begin
                    emit_idx <= emit_idx + 5'd1;
                end else begin
                    keymap   <= prev_snap;
                    emit_idx <= '0;
                    if (ctrl_en) begin
                        state   <= SCAN;
                        row_idx <= '0;
                        div_cnt <= '0;
                        row_o   <= ~ROW0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (flush || ovf_clr)
                ghost <= 1'b0;
        end
    end

    // NOTE: FIFO storage has no reset; count/pointers alone define its contents.
    always_ff @(posedge ACLK) begin
        if (push)
            mem[wr_ptr] <= {prev_snap[emit_idx], 3'b000, emit_idx};
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + 7'd1;
            else if (pop && !push) count <= count - 7'd1;
            if (ovf_clr)                  overflow <= 1'b0;
            else if (push_req && !push)   overflow <= 1'b1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            reg_rdata   <= '0;
            reg_rvalid  <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (reg_wr && reg_addr == 2'd0) begin
                ctrl_en     <= reg_wdata[0];
                ctrl_irq_en <= reg_wdata[1];
            end
            reg_rvalid <= reg_rd;
            if (reg_rd) begin
                case (reg_addr)
                    2'd0:    reg_rdata <= {30'd0, ctrl_irq_en, ctrl_en};
                    2'd1:    reg_rdata <= status;
                    2'd2:    reg_rdata <= empty ? 32'd0 : {1'b1, 22'd0, mem[rd_ptr]};
                    default: reg_rdata <= keymap;
                endcase
            end else begin
                reg_rdata <= '0;
            end
            irq <= ctrl_irq_en && (!empty || overflow);
        end
    end
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo: 4x4 matrix, SCAN_DIV=4, DEBOUNCE_SCANS=3, FIFO_DEPTH=8.
module tb_keypad_scan_fifo;
    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  row_o;
    logic [3:0]  col_i;
    logic [1:0]  reg_addr;
    logic        reg_wr;
    logic [31:0] reg_wdata;
    logic        reg_rd;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;
    logic        irq;

    logic [15:0] keys;
    logic [31:0] d;
    int          checks = 0;
    int          errors = 0;

    keypad_scan_fifo #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(3), .FIFO_DEPTH(8)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .row_o(row_o), .col_i(col_i),
        .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
        .reg_rd(reg_rd), .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    // Passive keypad: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col_i = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_o[r] && keys[r*4+c]) col_i[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] data);
        @(negedge ACLK);
        reg_addr = a;
        reg_rd   = 1'b1;
        @(negedge ACLK);
        reg_rd   = 1'b0;
        data     = reg_rdata;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] data);
        @(negedge ACLK);
        reg_addr  = a;
        reg_wdata = data;
        reg_wr    = 1'b1;
        @(negedge ACLK);
        reg_wr    = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    initial begin
        logic found;
        ARESET = 1'b1; reg_addr = '0; reg_wr = 1'b0; reg_wdata = '0; reg_rd = 1'b0; keys = '0;
        #1;
        check("reset_row", 32'(row_o), 32'hF);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_rvalid", 32'(reg_rvalid), 32'd0);
        check("reset_rdata", reg_rdata, 32'd0);
        wait_cycles(2);
        ARESET = 1'b0;
        read_reg(2'd1, d); check("reset_status", d, 32'h0000_0100);
        read_reg(2'd3, d); check("reset_keymap", d, 32'd0);
        read_reg(2'd0, d); check("reset_ctrl", d, 32'd0);

        // Single press of row 1, col 2.
        write_reg(2'd0, 32'd1);
        keys[6] = 1'b1;
        wait_cycles(200);
        read_reg(2'd1, d); check("press_status", d, 32'h0000_0001);
        check("press_irq_masked", 32'(irq), 32'd0);
        read_reg(2'd3, d); check("press_keymap", d, 32'h0000_0040);
        write_reg(2'd0, 32'd3);
        @(negedge ACLK);
        check("press_irq", 32'(irq), 32'd1);
        read_reg(2'd2, d); check("press_keydata", d, 32'h8000_0106);
        check("rvalid_pulse", 32'(reg_rvalid), 32'd1);
        @(negedge ACLK);
        check("rvalid_drop", 32'(reg_rvalid), 32'd0);
        @(negedge ACLK);
        check("irq_after_pop", 32'(irq), 32'd0);

        // Release.
        keys[6] = 1'b0;
        wait_cycles(200);
        read_reg(2'd2, d); check("release_keydata", d, 32'h8000_0006);
        read_reg(2'd2, d); check("empty_keydata", d, 32'd0);
        read_reg(2'd1, d); check("empty_status", d, 32'h0000_0100);

        // Bounce key 5 once per scan for 10 scans, then hold.
        for (int i = 0; i < 10; i++) begin
            keys[5] = ~keys[5];
            wait_cycles(16);
        end
        read_reg(2'd1, d); check("bounce_no_event", d, 32'h0000_0100);
        keys[5] = 1'b1;
        wait_cycles(200);
        read_reg(2'd1, d); check("bounce_one_event", d, 32'h0000_0001);
        read_reg(2'd2, d); check("bounce_keydata", d, 32'h8000_0105);
        keys[5] = 1'b0;
        wait_cycles(200);
        read_reg(2'd2, d); check("bounce_release", d, 32'h8000_0005);

        // Ten keys at once into an 8-deep FIFO.
        keys = 16'h03FF;
        wait_cycles(200);
`ifdef KEYPAD_GHOST_REJECT_EN
        read_reg(2'd1, d); check("ten_ghost_status", d, 32'h0000_0900);
        check("ten_ghost_irq", 32'(irq), 32'd0);
`else
        read_reg(2'd1, d); check("ten_status", d, 32'h0000_0608);
        check("ten_irq", 32'(irq), 32'd1);
        read_reg(2'd2, d); check("ten_first", d, 32'h8000_0100);
        read_reg(2'd2, d); check("ten_second", d, 32'h8000_0101);
        read_reg(2'd1, d); check("ten_after_pop", d, 32'h0000_0406);
`endif
        write_reg(2'd0, 32'd7);
        read_reg(2'd1, d); check("flush_status", d, 32'h0000_0100);
        @(negedge ACLK);
        check("flush_irq", 32'(irq), 32'd0);
        read_reg(2'd0, d); check("flush_selfclear", d, 32'h0000_0003);
        keys = '0;
        wait_cycles(200);
`ifndef KEYPAD_GHOST_REJECT_EN
        read_reg(2'd1, d); check("ten_rel_status", d, 32'h0000_0608);
`endif
        write_reg(2'd1, 32'h0000_0400);
`ifdef KEYPAD_GHOST_REJECT_EN
        read_reg(2'd1, d); check("ghost_clear", d, 32'h0000_0100);
`else
        read_reg(2'd1, d); check("ovf_clear", d, 32'h0000_0208);
        read_reg(2'd2, d); check("ten_rel_first", d, 32'h8000_0000);
`endif
        write_reg(2'd0, 32'd7);

        // Three keys: ghost rejection versus plain acceptance.
        keys = 16'h0421;
        wait_cycles(200);
`ifdef KEYPAD_GHOST_REJECT_EN
        read_reg(2'd1, d); check("three_ghost", d, 32'h0000_0900);
`else
        read_reg(2'd1, d); check("three_status", d, 32'h0000_0003);
        read_reg(2'd2, d); check("three_ev0", d, 32'h8000_0100);
        read_reg(2'd2, d); check("three_ev1", d, 32'h8000_0105);
        read_reg(2'd2, d); check("three_ev2", d, 32'h8000_010A);
`endif
        keys = '0;
        wait_cycles(200);
        write_reg(2'd1, 32'h0000_0400);
`ifdef KEYPAD_GHOST_REJECT_EN
        read_reg(2'd1, d); check("three_rel_ghost", d, 32'h0000_0100);
`else
        read_reg(2'd1, d); check("three_rel_status", d, 32'h0000_0003);
`endif
        write_reg(2'd0, 32'd3);

        // Reset in the middle of an event walk.
        keys = 16'h8001;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge ACLK);
            if (row_o === 4'hF) found = 1'b1;
        end
        check("emit_reached", 32'(found), 32'd1);
        wait_cycles(4);
        check("emit_irq", 32'(irq), 32'd1);
        ARESET = 1'b1;
        #1;
        check("areset_row", 32'(row_o), 32'hF);
        check("areset_irq", 32'(irq), 32'd0);
        wait_cycles(2);
        ARESET = 1'b0;
        read_reg(2'd1, d); check("areset_status", d, 32'h0000_0100);
        read_reg(2'd3, d); check("areset_keymap", d, 32'd0);
        wait_cycles(50);
        check("idle_after_reset", 32'(row_o), 32'hF);
        write_reg(2'd0, 32'd1);
        @(negedge ACLK);
        check("scan_resume", 32'(row_o), 32'hE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
